// File: rtl/decoder_3_8.sv
// N-to-2^N line decoder with enable, selectable polarity and optional output register.
// Latency 1 cycle (REGISTERED=1) or 0 (REGISTERED=0); no backpressure, one code per cycle.
module decoder_3_8 #(
   parameter int N          = 3,
   parameter int ACTIVE_LOW = 0,
   parameter int REGISTERED = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [N-1:0]        w,
   output logic [(1<<N)-1:0]   out,
   output logic                valid
);

   localparam int LINES = 1 << N;
   localparam logic [LINES-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {LINES{1'b1}} : {LINES{1'b0}};

   logic [LINES-1:0] hot;
   logic [LINES-1:0] dec;

   // An unknown w bit makes every equality X, so no line is set and the word stays inactive.
   always_comb begin
      hot = '0;
      for (int i = 0; i < LINES; i++) begin
         if (en && (w == N'(i))) begin
            hot[i] = 1'b1;
         end
      end
   end

   assign dec = (ACTIVE_LOW != 0) ? ~hot : hot;

   generate
      if (REGISTERED != 0) begin : g_reg
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               out   <= INACTIVE;
               valid <= 1'b0;
            end else begin
               out   <= dec;
               valid <= en;
            end
         end
      end else begin : g_comb
         assign out   = rst ? INACTIVE : dec;
         assign valid = rst ? 1'b0 : en;
      end
   endgenerate

endmodule

// File: tb/tb_decoder_3_8.sv
// Self-checking bench for decoder_3_8: default, active-low, combinational and N=4 builds.
module tb_decoder_3_8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [2:0]  w   = '0;
   logic [3:0]  w4  = '0;

   logic [7:0]  o0, o1, o2;
   logic [15:0] o3;
   logic        v0, v1, v2, v3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   decoder_3_8 u_def (.clk(clk), .rst(rst), .en(en), .w(w), .out(o0), .valid(v0));
   decoder_3_8 #(.ACTIVE_LOW(1)) u_low (.clk(clk), .rst(rst), .en(en), .w(w), .out(o1), .valid(v1));
   decoder_3_8 #(.REGISTERED(0)) u_comb (.clk(clk), .rst(rst), .en(en), .w(w), .out(o2), .valid(v2));
   decoder_3_8 #(.N(4)) u_n4 (.clk(clk), .rst(rst), .en(en), .w(w4), .out(o3), .valid(v3));

   typedef struct packed {
      logic       en;
      logic [2:0] w;
      logic [7:0] exp;
      logic       exp_vld;
   } vec_t;

   vec_t tbl[17];

   // Reference: selected line is bit number w of a 2^n-bit word, inverted for active-low.
   function automatic logic [15:0] ref_dec(int n, logic e, int sel, bit al);
      int          lines;
      logic [15:0] v;
      lines = 1 << n;
      v = e ? (16'd1 << sel) : 16'd0;
      if (al) v = ~v & 16'((1 << lines) - 1);
      return v;
   endfunction

   task automatic check(string name, logic [15:0] act, logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      logic [7:0] nexp;
      logic       re;
      logic [2:0] rw;
      logic [3:0] rw4;

      tbl[0]  = {1'b1, 3'd0, 8'h01, 1'b1};
      tbl[1]  = {1'b1, 3'd1, 8'h02, 1'b1};
      tbl[2]  = {1'b1, 3'd2, 8'h04, 1'b1};
      tbl[3]  = {1'b1, 3'd3, 8'h08, 1'b1};
      tbl[4]  = {1'b1, 3'd4, 8'h10, 1'b1};
      tbl[5]  = {1'b1, 3'd4, 8'h10, 1'b1};
      tbl[6]  = {1'b1, 3'd5, 8'h20, 1'b1};
      tbl[7]  = {1'b1, 3'd5, 8'h20, 1'b1};
      tbl[8]  = {1'b1, 3'd6, 8'h40, 1'b1};
      tbl[9]  = {1'b1, 3'd6, 8'h40, 1'b1};
      tbl[10] = {1'b1, 3'd7, 8'h80, 1'b1};
      tbl[11] = {1'b1, 3'd7, 8'h80, 1'b1};
      tbl[12] = {1'b1, 3'd3, 8'h08, 1'b1};
      tbl[13] = {1'b0, 3'd3, 8'h00, 1'b0};
      tbl[14] = {1'b1, 3'd3, 8'h08, 1'b1};
      tbl[15] = {1'b1, 3'd2, 8'h04, 1'b1};
      tbl[16] = {1'b0, 3'd6, 8'h00, 1'b0};

      // Power-on reset state
      #12;
      check("rst_out_def", 16'(o0), 16'h0000);
      check("rst_vld_def", 16'(v0), 16'h0000);
      check("rst_out_low", 16'(o1), 16'h00FF);
      check("rst_out_comb", 16'(o2), 16'h0000);
      check("rst_vld_comb", 16'(v2), 16'h0000);
      check("rst_out_n4", o3, 16'h0000);

      // Release: outputs hold inactive until the first edge samples the inputs
      @(negedge clk);
      rst = 1'b0; en = 1'b1; w = 3'b101;
      #1;
      check("rel_hold_out", 16'(o0), 16'h0000);
      check("rel_hold_vld", 16'(v0), 16'h0000);
      @(posedge clk); #1;
      check("rel_first_out", 16'(o0), 16'h0020);
      check("rel_first_vld", 16'(v0), 16'h0001);

      // Mid-cycle reset takes effect without a clock edge
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check("midrst_out_def", 16'(o0), 16'h0000);
      check("midrst_vld_def", 16'(v0), 16'h0000);
      check("midrst_out_low", 16'(o1), 16'h00FF);
      check("midrst_out_comb", 16'(o2), 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("postrst_out", 16'(o0), 16'h0020);
      check("postrst_vld", 16'(v0), 16'h0001);

      // Sweep with dwell, enable gating, and simultaneous en drop with w change
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         en = tbl[i].en; w = tbl[i].w;
         #1;
         check("tbl_comb_out", 16'(o2), 16'(tbl[i].exp));
         check("tbl_comb_vld", 16'(v2), 16'(tbl[i].exp_vld));
         @(posedge clk); #1;
         nexp = ~tbl[i].exp;
         check("tbl_out", 16'(o0), 16'(tbl[i].exp));
         check("tbl_vld", 16'(v0), 16'(tbl[i].exp_vld));
         check("tbl_onehot", 16'($countones(o0)), 16'(tbl[i].en ? 1 : 0));
         check("tbl_out_low", 16'(o1), 16'(nexp));
      end

      // Combinational build follows a mid-cycle w change with no edge
      @(negedge clk);
      en = 1'b1; w = 3'b000;
      #1;
      check("comb_w0", 16'(o2), 16'h0001);
      #2;
      w = 3'b111;
      #1;
      check("comb_w7", 16'(o2), 16'h0080);

      // Active-low selected line
      @(negedge clk);
      w = 3'b110;
      @(posedge clk); #1;
      check("low_w6", 16'(o1), 16'h00BF);

      // N=4 boundary codes
      @(negedge clk);
      en = 1'b1; w4 = 4'hF;
      @(posedge clk); #1;
      check("n4_wF", o3, 16'h8000);
      @(negedge clk);
      w4 = 4'h0;
      @(posedge clk); #1;
      check("n4_w0", o3, 16'h0001);
      check("n4_vld", 16'(v3), 16'h0001);

      // Randomized traffic against the reference model
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         re  = 1'($urandom_range(0, 3) != 0);
         rw  = 3'($urandom);
         rw4 = 4'($urandom);
         en = re; w = rw; w4 = rw4;
         #1;
         check("rnd_comb", 16'(o2), ref_dec(3, re, int'(rw), 1'b0));
         @(posedge clk); #1;
         check("rnd_def", 16'(o0), ref_dec(3, re, int'(rw), 1'b0));
         check("rnd_low", 16'(o1), ref_dec(3, re, int'(rw), 1'b1));
         check("rnd_n4", o3, ref_dec(4, re, int'(rw4), 1'b0));
         check("rnd_vld", 16'(v0), 16'(re));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
